// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: memory op codes, LSU state encoding and
// debug error causes.
package lsu_ctrl_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_FIN
  } lsu_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load lane select and
// extension, plus alignment and op legality flags.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_mem_op,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_resp_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wstrb    = '0;
    o_wdata    = '0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_mem_op)
      MEM_OP_B, MEM_OP_BU: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_OP_H, MEM_OP_HU: begin
        o_wstrb    = 4'b0011 << i_addr_lo;
        o_wdata    = {2{i_wdata[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      MEM_OP_W: begin
        o_wstrb    = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = |i_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      2'd0: w_byte = i_resp_rdata[7:0];
      2'd1: w_byte = i_resp_rdata[15:8];
      2'd2: w_byte = i_resp_rdata[23:16];
      2'd3: w_byte = i_resp_rdata[31:24];
      default: w_byte = '0;
    endcase
    w_half = i_addr_lo[1] ? i_resp_rdata[31:16] : i_resp_rdata[15:0];
  end

  always_comb begin
    o_rdata = '0;
    case (i_mem_op)
      MEM_OP_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
      MEM_OP_BU: o_rdata = {24'd0, w_byte};
      MEM_OP_H:  o_rdata = {{16{w_half[15]}}, w_half};
      MEM_OP_HU: o_rdata = {16'd0, w_half};
      MEM_OP_W:  o_rdata = i_resp_rdata;
      default:   o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory op, runs a valid/ready bus
// transaction with timeout, and returns extended load data with done/err.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mem_write,
  input  logic [2:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          req_valid,
  input  logic          req_ready,
  output logic          req_we,
  output logic [AW-1:0] req_addr,
  output logic [31:0]   req_wdata,
  output logic [3:0]    req_wstrb,
  input  logic          resp_valid,
  input  logic [31:0]   resp_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_addr_lo;
  logic [2:0]    r_mem_op;
  logic [1:0]    r_cause;
  logic          r_done;
  logic [31:0]   r_rdata;
  logic          r_req_valid;
  logic          r_req_we;
  logic [AW-1:0] r_req_addr;
  logic [31:0]   r_req_wdata;
  logic [3:0]    r_req_wstrb;

  logic          w_idle;
  logic [1:0]    w_addr_lo;
  logic [2:0]    w_mem_op;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic          w_misalign;
  logic          w_illegal;
  logic          w_tmo;

  // One align instance serves both phases: live inputs while IDLE, the
  // captured op/offset while the response is awaited.
  assign w_idle    = (r_state == LSU_IDLE);
  assign w_addr_lo = w_idle ? addr[1:0] : r_addr_lo;
  assign w_mem_op  = w_idle ? mem_op : r_mem_op;
  assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));

  lsu_align u_align (
    .i_addr_lo    (w_addr_lo),
    .i_mem_op     (w_mem_op),
    .i_wdata      (wdata),
    .i_resp_rdata (resp_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misalign   (w_misalign),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LSU_IDLE;
      r_cnt       <= '0;
      r_addr_lo   <= '0;
      r_mem_op    <= '0;
      r_cause     <= ERR_NONE;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          r_done  <= 1'b0;
          r_cause <= ERR_NONE;
          if (start) begin
            r_addr_lo <= addr[1:0];
            r_mem_op  <= mem_op;
            if (w_illegal || (mem_write && mem_op[2])) begin
              r_state <= LSU_FIN;
              r_done  <= 1'b1;
              r_cause <= ERR_ILLEGAL;
              r_rdata <= '0;
            end else if (w_misalign) begin
              r_state <= LSU_FIN;
              r_done  <= 1'b1;
              r_cause <= ERR_MISALIGN;
              r_rdata <= '0;
            end else begin
              r_state     <= LSU_REQ;
              r_cnt       <= '0;
              r_req_valid <= 1'b1;
              r_req_we    <= mem_write;
              r_req_addr  <= {addr[AW-1:2], 2'b00};
              r_req_wstrb <= mem_write ? w_wstrb : 4'b0000;
              r_req_wdata <= mem_write ? w_wdata : 32'd0;
            end
          end
        end
        LSU_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_tmo) begin
            r_req_valid <= 1'b0;
            r_state     <= LSU_FIN;
            r_done      <= 1'b1;
            r_cause     <= ERR_TIMEOUT;
            r_rdata     <= '0;
          end else if (req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (resp_valid) begin
            r_state <= LSU_FIN;
            r_done  <= 1'b1;
            r_cause <= ERR_NONE;
            r_rdata <= r_req_we ? 32'd0 : w_rdata;
          end else if (w_tmo) begin
            r_state <= LSU_FIN;
            r_done  <= 1'b1;
            r_cause <= ERR_TIMEOUT;
            r_rdata <= '0;
          end
        end
        LSU_FIN: begin
          r_done  <= 1'b0;
          r_cause <= ERR_NONE;
          r_state <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == LSU_REQ) || (r_state == LSU_WAIT) || (w_idle && start);
  assign done      = r_done;
  assign err       = (r_cause != ERR_NONE);
  assign rdata     = r_rdata;
  assign req_valid = r_req_valid;
  assign req_we    = r_req_we;
  assign req_addr  = r_req_addr;
  assign req_wdata = r_req_wdata;
  assign req_wstrb = r_req_wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table on a default instance, plus
// stall, timeout and reset sequences on default and short-timeout instances.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, mem_write = 1'b0, req_ready = 1'b0, resp_valid = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = '0, wdata = '0, resp_rdata = '0;
  logic        busy, done, err, req_valid, req_we;
  logic [31:0] rdata, req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  logic        t_start = 1'b0, t_mem_write = 1'b0, t_req_ready = 1'b0, t_resp_valid = 1'b0;
  logic [2:0]  t_mem_op = 3'b000;
  logic [31:0] t_addr = '0, t_wdata = '0, t_resp_rdata = '0;
  logic        t_busy, t_done, t_err, t_req_valid, t_req_we;
  logic [31:0] t_rdata, t_req_addr, t_req_wdata;
  logic [3:0]  t_req_wstrb;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_write(mem_write), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
  );

  lsu_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(t_start), .mem_write(t_mem_write), .mem_op(t_mem_op),
    .addr(t_addr), .wdata(t_wdata), .busy(t_busy), .done(t_done), .err(t_err),
    .rdata(t_rdata), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_wstrb(t_req_wstrb),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata)
  );

  typedef struct {
    logic        mw;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic        e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    @(negedge clk);
    start = 1'b1; mem_write = v.mw; mem_op = v.op; addr = v.addr; wdata = v.wdata;
    req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = v.resp;
    #1 chkb({p, " busy_start"}, busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    if (v.e_err) begin
      chkb({p, " done_err"}, done, 1'b1);
      chkb({p, " err"}, err, 1'b1);
      chkb({p, " no_req"}, req_valid, 1'b0);
      chkb({p, " busy_fin"}, busy, 1'b0);
      chk({p, " rdata"}, rdata, 32'd0);
    end else begin
      chkb({p, " req_valid"}, req_valid, 1'b1);
      chk({p, " req_addr"}, req_addr, {v.addr[31:2], 2'b00});
      chkb({p, " req_we"}, req_we, v.mw);
      chk({p, " req_wstrb"}, 32'(req_wstrb), 32'(v.e_strb));
      if (v.mw) chk({p, " req_wdata"}, req_wdata, v.e_wdata);
      chkb({p, " busy_req"}, busy, 1'b1);
      chkb({p, " done_req"}, done, 1'b0);
      @(negedge clk);
      chkb({p, " valid_drop"}, req_valid, 1'b0);
      chkb({p, " busy_wait"}, busy, 1'b1);
      resp_valid = 1'b1;
      @(negedge clk);
      resp_valid = 1'b0;
      chkb({p, " done"}, done, 1'b1);
      chkb({p, " err"}, err, 1'b0);
      chk({p, " rdata"}, rdata, v.e_rdata);
      chkb({p, " busy_fin"}, busy, 1'b0);
    end
    @(negedge clk);
    chkb({p, " done_pulse"}, done, 1'b0);
    chkb({p, " idle_valid"}, req_valid, 1'b0);
  endtask

  // Short-timeout instance: load at 0x20, optional response at cycle resp_at.
  task automatic t_run(input string nm, input logic rdy, input int resp_at,
                       input logic e_err, input logic [31:0] e_rdata);
    int n;
    @(negedge clk);
    t_start = 1'b1; t_mem_write = 1'b0; t_mem_op = MEM_OP_W; t_addr = 32'h20;
    t_req_ready = rdy; t_resp_valid = 1'b0; t_resp_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    t_start = 1'b0;
    n = 1;
    while (n < 9 && !t_done) begin
      if (n == 4) chkb({nm, " valid_c4"}, t_req_valid, ~rdy);
      t_resp_valid = (n == resp_at);
      @(negedge clk);
      n++;
    end
    t_resp_valid = 1'b0;
    chk({nm, " done_cycle"}, 32'(n), 32'd5);
    chkb({nm, " done"}, t_done, 1'b1);
    chkb({nm, " err"}, t_err, e_err);
    chk({nm, " rdata"}, t_rdata, e_rdata);
    chkb({nm, " valid_fin"}, t_req_valid, 1'b0);
    @(negedge clk);
    chkb({nm, " done_pulse"}, t_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h8000_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_0000, 1'b0, 4'b0000, 32'h0, 32'h0000_8001};
    vecs[4]  = '{1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_0000, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001};
    vecs[5]  = '{1'b0, 3'b000, 32'h4000_0011, 32'h0, 32'h1234_F678, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FFF6};
    vecs[6]  = '{1'b0, 3'b001, 32'h4000_0010, 32'h0, 32'h1234_8765, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8765};
    vecs[7]  = '{1'b0, 3'b100, 32'h4000_0012, 32'h0, 32'h1234_F678, 1'b0, 4'b0000, 32'h0, 32'h0000_0034};
    vecs[8]  = '{1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[9]  = '{1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h8000_0100, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h8000_0100, 32'h0000_BEEF, 32'h0, 1'b0, 4'b0011, 32'hBEEF_BEEF, 32'h0};
    vecs[12] = '{1'b1, 3'b000, 32'h8000_0103, 32'h0000_0011, 32'h0, 1'b0, 4'b1000, 32'h1111_1111, 32'h0};
    vecs[13] = '{1'b1, 3'b010, 32'h8000_0001, 32'h1111_1111, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[16] = '{1'b0, 3'b001, 32'h8000_0003, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[17] = '{1'b1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[18] = '{1'b0, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};

    repeat (2) @(negedge clk);
    chkb("rst busy", busy, 1'b0);
    chkb("rst done", done, 1'b0);
    chkb("rst err", err, 1'b0);
    chkb("rst req_valid", req_valid, 1'b0);
    chkb("rst req_we", req_we, 1'b0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst req_addr", req_addr, 32'd0);
    chk("rst req_wdata", req_wdata, 32'd0);
    chk("rst req_wstrb", 32'(req_wstrb), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Bus not ready for several cycles: request must stay frozen.
    @(negedge clk);
    start = 1'b1; mem_write = 1'b1; mem_op = MEM_OP_W; addr = 32'h1000_0008;
    wdata = 32'h5555_AAAA; req_ready = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chkb($sformatf("stall%0d valid", k), req_valid, 1'b1);
      chk($sformatf("stall%0d addr", k), req_addr, 32'h1000_0008);
      chk($sformatf("stall%0d wdata", k), req_wdata, 32'h5555_AAAA);
      chk($sformatf("stall%0d wstrb", k), 32'(req_wstrb), 32'hF);
      chkb($sformatf("stall%0d we", k), req_we, 1'b1);
      chkb($sformatf("stall%0d busy", k), busy, 1'b1);
      if (k == 3) req_ready = 1'b1;
      @(negedge clk);
    end
    chkb("stall wait_valid", req_valid, 1'b0);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    chkb("stall done", done, 1'b1);
    chkb("stall err", err, 1'b0);
    chk("stall rdata", rdata, 32'd0);

    t_run("tmo_wait", 1'b1, 0, 1'b1, 32'd0);
    t_run("tmo_req", 1'b0, 0, 1'b1, 32'd0);
    t_run("resp_wins", 1'b1, 4, 1'b0, 32'h0BAD_F00D);

    // Reset while waiting on the response.
    run_vec(0);
    @(negedge clk);
    start = 1'b1; mem_write = 1'b0; mem_op = MEM_OP_W; addr = 32'h8000_0010;
    req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chkb("rstw in_wait", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("rstw busy", busy, 1'b0);
    chkb("rstw done", done, 1'b0);
    chkb("rstw err", err, 1'b0);
    chkb("rstw req_valid", req_valid, 1'b0);
    chkb("rstw req_we", req_we, 1'b0);
    chk("rstw rdata", rdata, 32'd0);
    chk("rstw req_addr", req_addr, 32'd0);
    chk("rstw req_wstrb", 32'(req_wstrb), 32'd0);
    chk("rstw req_wdata", req_wdata, 32'd0);
    resp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    chkb("rstw late_resp_done", done, 1'b0);
    chk("rstw late_resp_rdata", rdata, 32'd0);
    @(negedge clk);
    chkb("rstw late_resp_done2", done, 1'b0);
    run_vec(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core datapath and a valid/ready data-memory bus.
- Accepts one memory op (mem_write, mem_op, addr, wdata) from the decode/execute stage and drives the bus transaction. It generates byte strobes and lane-shifted write data, then returns sign- or zero-extended load data.
- Holds the core stalled (busy) from acceptance until completion, misalignment error, or timeout.

Parameters:
- TIMEOUT, 255, bus cycles allowed from first req_valid to resp_valid before a bus error is reported; minimum 1.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request from datapath; sampled only in IDLE.
- mem_write  in  1  1 = store, 0 = load.
- mem_op  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 illegal.
- addr  in  AW  byte address.
- wdata  in  32  store data, low-aligned.
- busy  out  1  stall to core.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned, illegal op, or timeout.
- rdata  out  32  extended load data, valid with done.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_we  out  1  bus write enable.
- req_addr  out  AW  word-aligned address (addr[1:0] forced to 00).
- req_wdata  out  32  lane-shifted store data.
- req_wstrb  out  4  byte strobes; 0000 for loads.
- resp_valid  in  1  bus response or write-ack.
- resp_rdata  in  32  raw word read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, err, req_valid, req_we = 0. rdata, req_addr, req_wdata, req_wstrb = 0. Timeout counter = 0. Reset mid-transaction abandons it; a late resp_valid after reset is ignored.
- States: IDLE, REQ, WAIT, FIN.
- IDLE + start:
  - Check alignment: half needs addr[0]=0; word needs addr[1:0]=00.
  - Illegal op, illegal store size (mem_op[2]=1 with mem_write=1), or misalignment -> FIN with err=1, no bus activity.
  - Otherwise, register all request outputs and go to REQ.
  - start outside IDLE is ignored; the core keeps it stable while busy.
- Strobes and shift:
  - byte: wstrb = 0001 << addr[1:0]; wdata[7:0] replicated to all lanes.
  - half: wstrb = 0011 << addr[1:0]; wdata[15:0] replicated to both halves.
  - word: wstrb = 1111.
- REQ: req_valid = 1, with req_addr/req_we/req_wdata/req_wstrb held stable until req_ready. On req_valid & req_ready -> WAIT and drop req_valid the next cycle.
- WAIT: on resp_valid, capture resp_rdata for loads:
  - select lane by addr[1:0];
  - sign-extend for mem_op[2]=0, zero-extend for mem_op[2]=1;
  - go to FIN with err=0.
  - For stores, resp_valid is the write-ack; rdata = 0.
- Bus contract: resp_valid comes at least 1 cycle after the request handshake. resp_valid seen in IDLE, REQ or FIN is ignored.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no completion, go to FIN with err=1 and deassert req_valid. This is legal even mid-REQ, where valid is withdrawn.
  - resp_valid in the same cycle as the counter reaching TIMEOUT counts as success (response wins).
- FIN: done=1 for exactly one cycle, err/rdata valid, busy=0 in this cycle, then IDLE. A start in the cycle after FIN is accepted.
- busy = 1 in REQ and WAIT, and in the cycle start is sampled in IDLE (combinational start & IDLE term).
- Latency, zero-wait bus (ready=1, resp one cycle after accept): start at edge t, REQ during t+1, WAIT during t+2 with resp_valid, done during t+3. Error ops give done at t+1.

Decomposition:
- Shared package holds:
  - MEM_OP_* codes (B=000, H=001, W=010, BU=100, HU=101), also used by the instruction decoder;
  - lsu state enum;
  - ERR cause constants for debug.
- Sub-module lsu_align (combinational): addr[1:0], mem_op, wdata, resp_rdata -> wstrb, shifted wdata, extended rdata, misalign flag. Unit-testable in isolation.

Test Plan:
- lw addr=0x8000_0004, ready=1, resp_rdata=0xDEAD_BEEF next cycle -> req_addr=0x8000_0004, wstrb=0000, done at t+3, rdata=0xDEAD_BEEF, err=0.
- lb addr=0x...03, resp_rdata=0x80_00_00_00 -> rdata=0xFFFF_FF80; lbu same -> 0x0000_0080; lhu addr=0x...02, resp 0x8001_0000 -> 0x0000_8001.
- sh addr=0x...02, wdata=0x1234_ABCD -> req_we=1, wstrb=1100, req_wdata=0xABCD_ABCD; ack -> done, err=0.
- sw addr=0x...01 -> no req_valid ever, done at t+1, err=1; mem_op=011 likewise.
- req_ready held 0 for 3 cycles -> req_valid and all req_* fields stable, busy=1 throughout; completes after ready. With TIMEOUT=4 and no resp -> done with err=1 after 4 cycles, req_valid low.
- rst_n pulled low in WAIT -> all outputs 0 immediately; following resp_valid ignored; a new start after reset completes normally.
